ifetch_queue: RTL and testbench



---
 rtl/ifetch_queue.sv | 137 +++++++++++++
 tb/tb_ifetch_queue.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_queue
// Description : Decoupled instruction-fetch front end. Issues word fetches over
//               req/gnt/rvalid, buffers {pc, inst} in a FIFO for decode, and
//               flushes on redirect. Optional misaligned-redirect fault:
//               define IFQ_MISALIGN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   r_mem_data [DEPTH];
    logic [31:0]   r_mem_pc   [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_discard;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;

    logic [CW:0]   w_occupancy;
    logic          w_fault_halt;
    logic [31:0]   w_redirect_pc;
    logic          w_grant;
    logic          w_push;
    logic          w_pop;

    assign w_redirect_pc = {redirect_pc[31:2], 2'b00};

`ifdef IFQ_MISALIGN_CHECK_EN
    logic r_fault;

    // Any redirect re-evaluates the fault, so an aligned one clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fault <= 1'b0;
        end else if (redirect) begin
            r_fault <= (redirect_pc[1:0] != 2'b00);
        end
    end

    assign w_fault_halt = r_fault;
    assign fetch_fault  = r_fault;
`else
    logic w_unused_pc_lsb;

    assign w_unused_pc_lsb = ^redirect_pc[1:0];
    assign w_fault_halt    = 1'b0;
    assign fetch_fault     = 1'b0;
`endif

    // Buffered plus in-flight fetches never exceed DEPTH, so a push always fits.
    assign w_occupancy = {1'b0, r_count} + {1'b0, r_outstanding};
    assign imem_req    = !reset && !redirect && !w_fault_halt &&
                         (w_occupancy < (CW + 1)'(DEPTH));
    assign imem_addr   = r_fetch_pc;

    assign w_grant = imem_req && imem_gnt;
    assign w_push  = imem_rvalid && (r_discard == '0) && !redirect;
    assign w_pop   = inst_valid && inst_ready && !redirect;

    assign inst_valid = (r_count != '0);
    assign inst_data  = r_mem_data[r_rd_ptr];
    assign inst_pc    = r_mem_pc[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_data[i] <= 32'h0;
                r_mem_pc[i]   <= 32'h0;
            end
        end else begin
            r_outstanding <= r_outstanding + CW'(w_grant) - CW'(imem_rvalid);
            if (redirect) begin
                // Every response still owed after this cycle belongs to the old stream.
                r_fetch_pc <= w_redirect_pc;
                r_resp_pc  <= w_redirect_pc;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
                r_discard  <= r_outstanding - CW'(imem_rvalid);
            end else begin
                if (w_grant) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (imem_rvalid && (r_discard != '0)) begin
                    r_discard <= r_discard - CW'(1);
                end
                if (w_push) begin
                    r_mem_data[r_wr_ptr] <= imem_rdata;
                    r_mem_pc[r_wr_ptr]   <= r_resp_pc;
                    r_wr_ptr             <= r_wr_ptr + AW'(1);
                    r_resp_pc            <= r_resp_pc + 32'd4;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_queue
// Description : Directed bench for ifetch_queue with an in-order memory model
//               (rdata = address) and a scoreboard of expected fetch PCs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_queue;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fetch_fault;

    int errors = 0;
    int checks = 0;

    int lat    = 1;
    int budget = 0;
    int cyc    = 0;

    logic [31:0] exp_q [$];
    logic [31:0] pend_addr [$];
    int          pend_due  [$];

    ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst_data   (inst_data),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fetch_fault (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string tag);
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clk);
        checks++;
        assert (exp_q.size() == 0)
        else begin
            errors++;
            $error("FAIL %s observed=%0d pending expected=0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Memory model: grants while budget remains, answers in order after lat cycles.
    initial begin
        logic        g_fire;
        logic [31:0] g_addr;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            g_fire = imem_req && imem_gnt;
            g_addr = imem_addr;
            if (g_fire) budget--;
            @(posedge clk);
            #2;
            cyc++;
            if (reset) begin
                pend_addr.delete();
                pend_due.delete();
            end else if (g_fire) begin
                pend_addr.push_back(g_addr);
                pend_due.push_back(cyc - 1 + lat);
            end
            if (!reset && pend_due.size() != 0 && pend_due[0] <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = pend_addr.pop_front();
                void'(pend_due.pop_front());
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'h0;
            end
            imem_gnt = (budget > 0);
        end
    end

    // Scoreboard: every instruction accepted by decode must be the next expected PC.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!reset && !redirect && inst_valid && inst_ready) begin
                checks++;
                assert (exp_q.size() != 0)
                else begin
                    errors++;
                    $error("FAIL sb_unexpected observed_pc=%h expected=none", inst_pc);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("sb_pc", inst_pc, e);
                    chk("sb_data", inst_data, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          first;
        int          last;
        int          vcount;
        int          ngr;
        int          gi;
        logic [31:0] wrap_addr [3];

        reset       = 1'b1;
        inst_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        repeat (3) step();
        @(negedge clk);
        chk("rst_req",   imem_req,    1'b0);
        chk("rst_valid", inst_valid,  1'b0);
        chk("rst_data",  inst_data,   32'h0);
        chk("rst_pc",    inst_pc,     32'h0);
        chk("rst_fault", fetch_fault, 1'b0);

        // Streaming: first instruction two cycles after first grant, then one per cycle.
        step();
        reset = 1'b0; lat = 1; budget = 4; inst_ready = 1'b1;
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        exp_q.push_back(32'h8); exp_q.push_back(32'hC);
        first = -1; last = -1; vcount = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk("p1_req0", imem_req && imem_gnt, 1'b1);
                chk("p1_addr0", imem_addr, 32'h0);
            end
            if (inst_valid) begin
                if (first < 0) first = k;
                last = k;
                vcount++;
            end
        end
        chk("p1_first_valid", first, 2);
        chk("p1_valid_cycles", vcount, 4);
        chk("p1_back_to_back", last - first, 3);
        wait_drain("p1_drain");

        // Decode stall: FIFO fills to DEPTH and requests stop.
        step(); reset = 1'b1; inst_ready = 1'b0; budget = 0;
        step(); reset = 1'b0; budget = 100;
        ngr = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (imem_req && imem_gnt) ngr++;
        end
        chk("p2_grants", ngr, 4);
        chk("p2_req_low", imem_req, 1'b0);
        step(); budget = 0; inst_ready = 1'b1;
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        exp_q.push_back(32'h8); exp_q.push_back(32'hC);
        wait_drain("p2_drain");

        // Redirect with two slow responses in flight: both are dropped.
        step(); reset = 1'b1; budget = 0; lat = 3;
        step(); reset = 1'b0; budget = 2; inst_ready = 1'b1;
        @(negedge clk); step();
        @(negedge clk); step();
        redirect = 1'b1; redirect_pc = 32'h100; budget = 1;
        exp_q.push_back(32'h100);
        @(negedge clk);
        chk("p3_req_redirect", imem_req, 1'b0);
        step(); redirect = 1'b0;
        @(negedge clk);
        chk("p3_req_resume", imem_req, 1'b1);
        chk("p3_addr", imem_addr, 32'h100);
        wait_drain("p3_drain");

        // Redirect colliding with rvalid and a pop on a non-empty FIFO.
        step(); reset = 1'b1; budget = 0; lat = 2;
        step(); reset = 1'b0; budget = 3; inst_ready = 1'b1;
        @(negedge clk); step();
        @(negedge clk); step();
        @(negedge clk); step();
        redirect = 1'b1; redirect_pc = 32'h300; budget = 1;
        exp_q.push_back(32'h300);
        @(negedge clk);
        chk("p4_pre_valid", inst_valid, 1'b1);
        chk("p4_pre_rvalid", imem_rvalid, 1'b1);
        chk("p4_req_redirect", imem_req, 1'b0);
        step(); redirect = 1'b0;
        @(negedge clk);
        chk("p4_flushed", inst_valid, 1'b0);
        wait_drain("p4_drain");

        // Address wrap-around at the top of the 32-bit space.
        wrap_addr[0] = 32'hFFFF_FFF8;
        wrap_addr[1] = 32'hFFFF_FFFC;
        wrap_addr[2] = 32'h0000_0000;
        step(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8; lat = 1; budget = 3;
        for (int i = 0; i < 3; i++) exp_q.push_back(wrap_addr[i]);
        step(); redirect = 1'b0;
        gi = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (imem_req && imem_gnt && gi < 3) begin
                chk("p5_wrap_addr", imem_addr, wrap_addr[gi]);
                gi++;
            end
        end
        chk("p5_grants", gi, 3);
        wait_drain("p5_drain");

`ifdef IFQ_MISALIGN_CHECK_EN
        step(); redirect = 1'b1; redirect_pc = 32'h102; budget = 1;
        step(); redirect = 1'b0;
        @(negedge clk);
        chk("p6_fault_set", fetch_fault, 1'b1);
        ngr = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (imem_req) ngr++;
        end
        chk("p6_halt_reqs", ngr, 0);
        step(); redirect = 1'b1; redirect_pc = 32'h200;
        exp_q.push_back(32'h200);
        step(); redirect = 1'b0;
        @(negedge clk);
        chk("p6_fault_clr", fetch_fault, 1'b0);
        chk("p6_req", imem_req, 1'b1);
        chk("p6_addr", imem_addr, 32'h200);
        wait_drain("p6_drain");
`else
        step(); redirect = 1'b1; redirect_pc = 32'h102; budget = 1;
        exp_q.push_back(32'h100);
        step(); redirect = 1'b0;
        @(negedge clk);
        chk("p6_req", imem_req, 1'b1);
        chk("p6_addr_aligned", imem_addr, 32'h100);
        chk("p6_fault", fetch_fault, 1'b0);
        wait_drain("p6_drain");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
